fp_norm24: RTL and testbench

Post-add normalizer for the single-precision FPU datapath. It takes the raw 25-bit sum from the mantissa adder (bit 24 = carry-out) with its tentative biased exponent. It produces a normalized 24-bit mantissa (hidden bit at bit 23) with the adjusted exponent: a left shift by leading-zero count, or a 1-bit right shift on carry. It is the left-shift counterpart of the alignment right-shifter that feeds the adder. The block is a 2-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_norm24.sv | 163 ++++++++++++++++
 tb/tb_fp_norm24.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm24.sv
// Post-add normalizer: 2-stage pipeline turning a raw 25-bit adder sum into a normalized 24-bit mantissa.
// Optional gradual underflow (denormal output) is enabled with `define FP_NORM_DENORM_EN.
module fp_norm24 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [23:0] out_mant,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_unf
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and a stalled output holds every data bit stable.

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Stage 1 registers
    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [7:0]  s1_exp_q;
    logic [23:0] s1_mant_q;
    logic        s1_carry_q;
    logic        s1_mz_q;
    logic [4:0]  s1_lz_q;

    logic        s1_carry_d;
    logic        s1_mz_d;
    logic [4:0]  s1_lz_d;

    // Stage 2 (output) registers
    logic        out_valid_q;
    logic        out_sign_q;
    logic [7:0]  out_exp_q;
    logic [23:0] out_mant_q;
    logic        out_zero_q;
    logic        out_ovf_q;
    logic        out_unf_q;

    logic [7:0]  out_exp_d;
    logic [23:0] out_mant_d;
    logic        out_zero_d;
    logic        out_ovf_d;
    logic        out_unf_d;

    logic        s2_adv;
    logic        s1_adv;
    logic [8:0]  exp9;
    logic [8:0]  lz9;
`ifdef FP_NORM_DENORM_EN
    logic [8:0]  sh9;
`endif

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s2_adv || !s1_valid_q;
    assign in_ready = s1_adv;

    assign s1_carry_d = in_mant[24];
    assign s1_mz_d    = (in_mant == 25'd0);
    assign s1_lz_d    = lzc24(in_mant[23:0]);

    assign exp9 = {1'b0, s1_exp_q};
    assign lz9  = {4'd0, s1_lz_q};
`ifdef FP_NORM_DENORM_EN
    assign sh9  = (exp9 == 9'd0) ? 9'd0 : exp9 - 9'd1;
`endif

    always_comb begin
        out_exp_d  = 8'd0;
        out_mant_d = 24'd0;
        out_zero_d = 1'b0;
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        if (s1_mz_q) begin
            out_zero_d = 1'b1;
        end else if (s1_carry_q && (s1_exp_q == 8'hFE)) begin
            out_exp_d = 8'hFF;
            out_ovf_d = 1'b1;
        end else if (s1_carry_q) begin
            out_mant_d = {1'b1, s1_mant_q[23:1]};
            out_exp_d  = 8'(exp9 + 9'd1);
        end else if (exp9 > lz9) begin
            out_mant_d = s1_mant_q << s1_lz_q;
            out_exp_d  = 8'(exp9 - lz9);
        end else begin
            out_unf_d = 1'b1;
`ifdef FP_NORM_DENORM_EN
            // in_exp <= lz here, so shifting by in_exp-1 never pushes a set bit out
            out_mant_d = s1_mant_q << sh9;
`else
            out_zero_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 8'd0;
            s1_mant_q  <= 24'd0;
            s1_carry_q <= 1'b0;
            s1_mz_q    <= 1'b0;
            s1_lz_q    <= 5'd0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q  <= in_sign;
                s1_exp_q   <= in_exp;
                s1_mant_q  <= in_mant[23:0];
                s1_carry_q <= s1_carry_d;
                s1_mz_q    <= s1_mz_d;
                s1_lz_q    <= s1_lz_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= 8'd0;
            out_mant_q  <= 24'd0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign_q <= s1_sign_q;
                out_exp_q  <= out_exp_d;
                out_mant_q <= out_mant_d;
                out_zero_q <= out_zero_d;
                out_ovf_q  <= out_ovf_d;
                out_unf_q  <= out_unf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_norm24.sv
// Bench for fp_norm24: directed vector table, back-pressured stream and mid-flight reset.
// Underflow expectations follow `FP_NORM_DENORM_EN the same way the design does.
module tb_fp_norm24;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    // packed result: {sign, exp, mant, zero, ovf, unf}
    logic [35:0] res;
    assign res = {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf};

    fp_norm24 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [35:0] exp_res;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl[NV];
    logic [35:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [24:0] m,
                                input logic [7:0] oe, input logic [23:0] om,
                                input logic z, input logic o, input logic u);
        vec_t v;
        v.sign    = s;
        v.exp     = e;
        v.mant    = m;
        v.exp_res = {s, oe, om, z, o, u};
        return v;
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_sign = v.sign;
        in_exp  = v.exp;
        in_mant = v.mant;
    endtask

    task automatic run_one(input vec_t v, input string name);
        int n;
        n = 0;
        in_valid = 1'b1;
        drive(v);
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, 36'(n + 1), 36'd2);
        chk(name, res, v.exp_res);
        tick();
    endtask

    initial begin
        int cyc, sent, got, gaps;
        logic held_v, saw_stall;
        logic [35:0] held, e;

        tbl[0]  = mk(1'b0, 8'h80, 25'h0000001, 8'h69, 24'h800000, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 8'h80, 25'h1800000, 8'h81, 24'hC00000, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 8'hFE, 25'h1000000, 8'hFF, 24'h000000, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 8'h55, 25'h0000000, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b0);
`ifdef FP_NORM_DENORM_EN
        tbl[4]  = mk(1'b0, 8'h03, 25'h0000100, 8'h00, 24'h000400, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 8'h01, 25'h0400000, 8'h00, 24'h400000, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 8'h00, 25'h0800000, 8'h00, 24'h800000, 1'b0, 1'b0, 1'b1);
`else
        tbl[4]  = mk(1'b0, 8'h03, 25'h0000100, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 8'h01, 25'h0400000, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 8'h00, 25'h0800000, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b1);
`endif
        tbl[7]  = mk(1'b0, 8'h7F, 25'h0800000, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 8'hFD, 25'h1FFFFFF, 8'hFE, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 8'h02, 25'h0400000, 8'h01, 24'h800000, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 25'h1000001, 8'h01, 24'h800000, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 8'h90, 25'h0000F00, 8'h84, 24'hF00000, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = 8'd0;
        in_mant = 25'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", res, 36'd0);
        chk("reset_valid", {35'd0, out_valid}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {35'd0, in_ready}, 36'd1);
        tick();

        for (int i = 0; i < NV; i++) begin
            run_one(tbl[i], $sformatf("vec%0d", i));
        end

        // stream of 8 back-to-back operands, output stalled during cycles 3..6
        cyc = 0; sent = 0; got = 0; gaps = 0;
        held_v = 1'b0; saw_stall = 1'b0; held = '0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 8) begin
                in_valid = 1'b1;
                drive(tbl[sent]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (held_v) chk("stall_hold", res, held);
            held_v = out_valid && !out_ready;
            held = res;
            if (out_valid && !in_ready) saw_stall = 1'b1;
            if (got > 0 && !out_valid) gaps++;
            if (in_valid && in_ready) begin
                exp_q.push_back(tbl[sent].exp_res);
                sent++;
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
                chk($sformatf("stream%0d", got), res, e);
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 36'(got), 36'd8);
        chk("stream_gaps", 36'(gaps), 36'd0);
        chk("stream_in_ready_drop", {35'd0, saw_stall}, 36'd1);
        chk("stream_leftover", 36'(exp_q.size()), 36'd0);
        repeat (2) tick();

        // two operands in flight, then asynchronous reset
        in_valid = 1'b1;
        drive(tbl[0]);
        tick();
        drive(tbl[1]);
        tick();
        in_valid = 1'b0;
        chk("inflight_valid", {35'd0, out_valid}, 36'd1);
        rst = 1'b1;
        #1;
        chk("midreset_valid", {35'd0, out_valid}, 36'd0);
        chk("midreset_outputs", res, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_in_ready", {35'd0, in_ready}, 36'd1);
        held_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) held_v = 1'b1;
        end
        chk("no_stale_result", {35'd0, held_v}, 36'd0);
        run_one(tbl[11], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
